// File: rtl/spi_responder.sv
`default_nettype none
// ============================================================================
//  Module   : spi_responder
//  Purpose  : SPI target (mode 0, MSB first). SCLK/SSN/MOSI are oversampled
//             in the clkin domain. Received bytes are presented on a
//             byte-wide rx register, and bytes to return come from a
//             byte-wide tx holding register.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Optional feature macro: SPI_RESPONDER_ECHO_EN
//    When defined, a reload with no tx byte pending sends the last completed
//    received byte (0 after reset) instead of FILL. This gives a loopback
//    target for bring-up.
// ----------------------------------------------------------------------------
//  Ports
//    clkin    in   system clock
//    rst_n    in   asynchronous active-low reset
//    sclk     in   SPI clock (asynchronous)
//    ssn      in   SPI select, active low (asynchronous)
//    mosi     in   serial data in (asynchronous)
//    miso     out  serial data out
//    miso_oe  out  pad output enable, high while selected
//    txdata   in   byte to send
//    txload   in   write strobe for txdata
//    txempty  out  tx holding register free
//    rxdata   out  last received byte
//    rxvalid  out  rxdata unread
//    rxack    in   unload strobe, clears rxvalid and overrun
//    overrun  out  sticky, a byte was lost while rxvalid was set
//    busy     out  transfer in progress (synchronised ssn low)
// ============================================================================
module spi_responder #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] FILL  = 8'h00
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             sclk,
    input  logic             ssn,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] txdata,
    input  logic             txload,
    output logic             txempty,
    output logic [WIDTH-1:0] rxdata,
    output logic             rxvalid,
    input  logic             rxack,
    output logic             overrun,
    output logic             busy
);

    localparam int               CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Synchronisers, plus a history flop on sclk/ssn for edge detection
    logic sclk_m_q, sclk_s_q, sclk_h_q;
    logic ssn_m_q,  ssn_s_q,  ssn_h_q;
    logic mosi_m_q, mosi_s_q;

    state_e             state_q,   state_d;
    logic [WIDTH-1:0]   shift_q,   shift_d;
    logic [CNT_W-1:0]   bitcnt_q,  bitcnt_d;
    logic               miso_q,    miso_d;
    logic [WIDTH-1:0]   txhold_q,  txhold_d;
    logic               txempty_q, txempty_d;
    logic [WIDTH-1:0]   rxdata_q,  rxdata_d;
    logic               rxvalid_q, rxvalid_d;
    logic               overrun_q, overrun_d;
`ifdef SPI_RESPONDER_ECHO_EN
    logic [WIDTH-1:0]   lastrx_q,  lastrx_d;
`endif

    logic             sclk_rise, sclk_fall, ssn_fall;
    logic             reload, rx_done;
    logic [WIDTH-1:0] reload_val, rx_byte;

    assign sclk_rise = sclk_s_q & ~sclk_h_q;
    assign sclk_fall = ~sclk_s_q & sclk_h_q;
    assign ssn_fall  = ~ssn_s_q & ssn_h_q;

    // Byte completed on this rising edge: current shifter plus incoming bit
    assign rx_byte = {shift_q[WIDTH-2:0], mosi_s_q};

`ifdef SPI_RESPONDER_ECHO_EN
    assign reload_val = txempty_q ? lastrx_q : txhold_q;
`else
    assign reload_val = txempty_q ? FILL : txhold_q;
`endif

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bitcnt_d  = bitcnt_q;
        miso_d    = miso_q;
        txhold_d  = txhold_q;
        txempty_d = txempty_q;
        rxdata_d  = rxdata_q;
        rxvalid_d = rxvalid_q;
        overrun_d = overrun_q;
`ifdef SPI_RESPONDER_ECHO_EN
        lastrx_d  = lastrx_q;
`endif
        reload    = 1'b0;
        rx_done   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                miso_d   = 1'b0;
                bitcnt_d = '0;
                if (ssn_fall) begin
                    state_d = ST_SHIFT;
                    reload  = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (ssn_s_q) begin
                    // Deselect aborts: partial byte and loaded shifter dropped
                    state_d  = ST_IDLE;
                    miso_d   = 1'b0;
                    bitcnt_d = '0;
                end else if (sclk_rise) begin
                    shift_d = rx_byte;
                    if (bitcnt_q == CNT_LAST) begin
                        bitcnt_d = '0;
                        rx_done  = 1'b1;
                    end else begin
                        bitcnt_d = bitcnt_q + CNT_W'(1);
                    end
                end else if (sclk_fall) begin
                    // A zero count on a falling edge means a byte just ended
                    if (bitcnt_q == '0) begin
                        reload = 1'b1;
                    end else begin
                        miso_d = shift_q[WIDTH-1];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (reload) begin
            shift_d = reload_val;
            miso_d  = reload_val[WIDTH-1];
            if (!txempty_q) begin
                txempty_d = 1'b1;
            end
        end

        // Only accepted when the holding register was free at cycle start,
        // so a same-cycle reload always takes the older byte.
        if (txload && txempty_q) begin
            txhold_d  = txdata;
            txempty_d = 1'b0;
        end

        if (rxack) begin
            rxvalid_d = 1'b0;
            overrun_d = 1'b0;
        end
        if (rx_done) begin
`ifdef SPI_RESPONDER_ECHO_EN
            lastrx_d = rx_byte;
`endif
            if (!rxvalid_q || rxack) begin
                rxdata_d  = rx_byte;
                rxvalid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            sclk_m_q  <= 1'b0;
            sclk_s_q  <= 1'b0;
            sclk_h_q  <= 1'b0;
            ssn_m_q   <= 1'b1;
            ssn_s_q   <= 1'b1;
            ssn_h_q   <= 1'b1;
            mosi_m_q  <= 1'b0;
            mosi_s_q  <= 1'b0;
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bitcnt_q  <= '0;
            miso_q    <= 1'b0;
            txhold_q  <= '0;
            txempty_q <= 1'b1;
            rxdata_q  <= '0;
            rxvalid_q <= 1'b0;
            overrun_q <= 1'b0;
`ifdef SPI_RESPONDER_ECHO_EN
            lastrx_q  <= '0;
`endif
        end else begin
            sclk_m_q  <= sclk;
            sclk_s_q  <= sclk_m_q;
            sclk_h_q  <= sclk_s_q;
            ssn_m_q   <= ssn;
            ssn_s_q   <= ssn_m_q;
            ssn_h_q   <= ssn_s_q;
            mosi_m_q  <= mosi;
            mosi_s_q  <= mosi_m_q;
            state_q   <= state_d;
            shift_q   <= shift_d;
            bitcnt_q  <= bitcnt_d;
            miso_q    <= miso_d;
            txhold_q  <= txhold_d;
            txempty_q <= txempty_d;
            rxdata_q  <= rxdata_d;
            rxvalid_q <= rxvalid_d;
            overrun_q <= overrun_d;
`ifdef SPI_RESPONDER_ECHO_EN
            lastrx_q  <= lastrx_d;
`endif
        end
    end

    assign miso    = miso_q;
    assign miso_oe = (state_q == ST_SHIFT);
    assign busy    = (state_q == ST_SHIFT);
    assign txempty = txempty_q;
    assign rxdata  = rxdata_q;
    assign rxvalid = rxvalid_q;
    assign overrun = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_responder
//  Purpose  : Directed self-checking bench for spi_responder acting as an
//             SPI mode 0 initiator with hand-computed expected values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_responder;

`ifdef SPI_RESPONDER_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif
    localparam int HALF = 8;   // sclk half period in clkin cycles

    logic       clkin = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk  = 1'b0;
    logic       ssn   = 1'b1;
    logic       mosi  = 1'b0;
    logic       miso, miso_oe, txempty, rxvalid, overrun, busy;
    logic [7:0] txdata = 8'h00;
    logic       txload = 1'b0;
    logic [7:0] rxdata;
    logic       rxack  = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    spi_responder #(.WIDTH(8), .FILL(8'h00)) dut (
        .clkin   (clkin),
        .rst_n   (rst_n),
        .sclk    (sclk),
        .ssn     (ssn),
        .mosi    (mosi),
        .miso    (miso),
        .miso_oe (miso_oe),
        .txdata  (txdata),
        .txload  (txload),
        .txempty (txempty),
        .rxdata  (rxdata),
        .rxvalid (rxvalid),
        .rxack   (rxack),
        .overrun (overrun),
        .busy    (busy)
    );

    always #5 clkin = ~clkin;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clkin);
    endtask

    task automatic do_txload(input logic [7:0] v);
        txdata = v;
        txload = 1'b1;
        wait_cyc(1);
        txload = 1'b0;
        wait_cyc(1);
    endtask

    task automatic do_rxack();
        rxack = 1'b1;
        wait_cyc(1);
        rxack = 1'b0;
        wait_cyc(1);
    endtask

    task automatic select();
        ssn = 1'b0;
        wait_cyc(HALF);
    endtask

    task automatic deselect();
        ssn = 1'b1;
        wait_cyc(HALF);
    endtask

    // Shift nbits MSB first; miso sampled just before each rising edge.
    // rxvalid is sampled 2 and 3 clkin cycles after the last rising edge.
    task automatic spi_xfer(input logic [7:0] mo, input int nbits,
                            output logic [7:0] mi, output logic rv_e, output logic rv_l);
        mi   = 8'h00;
        rv_e = 1'b0;
        rv_l = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[7-i];
            wait_cyc(HALF);
            mi[7-i] = miso;
            sclk = 1'b1;
            if (i == nbits - 1) begin
                wait_cyc(2);
                rv_e = rxvalid;
                wait_cyc(1);
                rv_l = rxvalid;
                wait_cyc(HALF - 3);
            end else begin
                wait_cyc(HALF);
            end
            sclk = 1'b0;
        end
    endtask

    logic [7:0] got;
    logic       rv_e, rv_l;

    initial begin
        wait_cyc(3);
        // Reset state
        check("rst_miso",    32'(miso),    32'd0);
        check("rst_miso_oe", 32'(miso_oe), 32'd0);
        check("rst_txempty", 32'(txempty), 32'd1);
        check("rst_rxdata",  32'(rxdata),  32'h00);
        check("rst_rxvalid", 32'(rxvalid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        rst_n = 1'b1;
        wait_cyc(3);

        // Plain receive, no tx pending
        select();
        check("t1_miso_oe", 32'(miso_oe), 32'd1);
        check("t1_busy",    32'(busy),    32'd1);
        spi_xfer(8'hA5, 8, got, rv_e, rv_l);
        check("t1_miso",       32'(got),     32'h00);
        check("t1_rv_2cyc",    32'(rv_e),    32'd0);
        check("t1_rv_3cyc",    32'(rv_l),    32'd1);
        check("t1_rxdata",     32'(rxdata),  32'hA5);
        check("t1_overrun",    32'(overrun), 32'd0);
        deselect();
        check("t1_oe_off", 32'(miso_oe), 32'd0);
        do_rxack();
        check("t1_rxack", 32'(rxvalid), 32'd0);

        // tx byte, second txload while full is dropped
        do_txload(8'h3C);
        check("t2_txempty0", 32'(txempty), 32'd0);
        do_txload(8'h77);
        select();
        check("t2_txempty1", 32'(txempty), 32'd1);
        spi_xfer(8'h11, 8, got, rv_e, rv_l);
        check("t2_miso0",   32'(got),    32'h3C);
        check("t2_rxdata0", 32'(rxdata), 32'h11);
        do_rxack();
        spi_xfer(8'h22, 8, got, rv_e, rv_l);
        check("t2_miso1",   32'(got),    ECHO ? 32'h11 : 32'h00);
        check("t2_rxdata1", 32'(rxdata), 32'h22);
        deselect();
        do_rxack();

        // Overrun
        select();
        spi_xfer(8'h55, 8, got, rv_e, rv_l);
        spi_xfer(8'h66, 8, got, rv_e, rv_l);
        check("t3_rxdata",  32'(rxdata),  32'h55);
        check("t3_overrun", 32'(overrun), 32'd1);
        check("t3_rxvalid", 32'(rxvalid), 32'd1);
        do_rxack();
        check("t3_ack_rv", 32'(rxvalid), 32'd0);
        check("t3_ack_ov", 32'(overrun), 32'd0);
        deselect();

        // Partial byte aborted by deselect
        select();
        spi_xfer(8'hFF, 5, got, rv_e, rv_l);
        deselect();
        check("t4_rxvalid", 32'(rxvalid), 32'd0);
        check("t4_miso_oe", 32'(miso_oe), 32'd0);
        check("t4_busy",    32'(busy),    32'd0);
        select();
        spi_xfer(8'h81, 8, got, rv_e, rv_l);
        check("t4_rxdata",  32'(rxdata),  32'h81);
        check("t4_rxvalid1", 32'(rxvalid), 32'd1);
        deselect();
        do_rxack();

        // Asynchronous reset mid-byte with a tx byte loaded
        do_txload(8'hF0);
        select();
        spi_xfer(8'h00, 3, got, rv_e, rv_l);
        rst_n = 1'b0;
        #1;
        check("t5_miso",    32'(miso),    32'd0);
        check("t5_miso_oe", 32'(miso_oe), 32'd0);
        check("t5_txempty", 32'(txempty), 32'd1);
        check("t5_rxdata",  32'(rxdata),  32'h00);
        check("t5_busy",    32'(busy),    32'd0);
        ssn  = 1'b1;
        sclk = 1'b0;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(4);
        select();
        spi_xfer(8'h42, 8, got, rv_e, rv_l);
        check("t5_fill",   32'(got),    32'h00);
        check("t5_rxdata2", 32'(rxdata), 32'h42);
        deselect();
        do_rxack();

        // Reload with nothing pending: FILL, or the last byte when echoing
        select();
        spi_xfer(8'h9E, 8, got, rv_e, rv_l);
        check("t6_miso0",  32'(got),    ECHO ? 32'h42 : 32'h00);
        check("t6_rxdata", 32'(rxdata), 32'h9E);
        spi_xfer(8'h00, 8, got, rv_e, rv_l);
        check("t6_miso1",  32'(got),    ECHO ? 32'h9E : 32'h00);
        deselect();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
